// File: rtl/dram_cmd_model.sv
// Cycle-accurate single-bank DRAM device model: command decode, open-row FSM,
// byte-masked array, CL-deep read pipeline. `DRAM_TIMING_CHECK_EN adds tRCD/tRP checks.
module dram_cmd_model #(
    parameter int ROW_BITS = 11,
    parameter int COL_BITS = 10,
    parameter int CL       = 5,
    parameter int T_RCD    = 5,
    parameter int T_RP     = 5
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        CSn,
    input  logic        RASn,
    input  logic        CASn,
    input  logic [3:0]  WEn,
    input  logic [10:0] A,
    input  logic [31:0] D,
    output logic [31:0] Q,
    output logic        VALID,
    output logic        ROW_OPEN,
    output logic        ERR
);
    localparam int AW    = ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {ST_CLOSED, ST_OPEN} state_t;

    state_t              state_q;
    logic [ROW_BITS-1:0] row_q;
    logic                row_open_q;
    logic                err_q;
    logic [CL-1:0]       rd_v_q;
    logic [31:0]         mem_rd_word;
    logic                timing_viol;

    logic cmd_act, cmd_pre, cmd_rd, cmd_wr, cmd_bad;
    logic act_go, pre_go, rd_go, wr_go;
    logic [AW-1:0] mem_addr;

    assign cmd_act = !CSn && !RASn &&  CASn && (WEn == 4'hF);
    assign cmd_pre = !CSn && !RASn &&  CASn && (WEn == 4'h0);
    assign cmd_rd  = !CSn &&  RASn && !CASn && (WEn == 4'hF);
    assign cmd_wr  = !CSn &&  RASn && !CASn && (WEn != 4'hF);
    assign cmd_bad = !CSn && !RASn && (WEn != 4'hF) && (WEn != 4'h0);

    assign act_go = cmd_act && (state_q == ST_CLOSED);
    assign pre_go = cmd_pre && (state_q == ST_OPEN);
    assign rd_go  = cmd_rd  && (state_q == ST_OPEN);
    assign wr_go  = cmd_wr  && (state_q == ST_OPEN);

    // A[10] is deliberately not part of the column address.
    assign mem_addr = {row_q, A[COL_BITS-1:0]};

`ifdef DRAM_TIMING_CHECK_EN
    localparam int RCD_LOAD = (T_RCD > 0) ? T_RCD - 1 : 0;
    localparam int RP_LOAD  = (T_RP > 0) ? T_RP - 1 : 0;
    localparam int CW       = $clog2(((T_RCD > T_RP) ? T_RCD : T_RP) + 2);

    // Down-counters: remaining edges before the next dependent command is legal.
    logic [CW-1:0] rcd_rem_q, rp_rem_q;

    assign timing_viol = (act_go && (rp_rem_q != '0)) ||
                         ((rd_go || wr_go) && (rcd_rem_q != '0));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rcd_rem_q <= '0;
            rp_rem_q  <= '0;
        end else begin
            if (act_go)
                rcd_rem_q <= CW'(RCD_LOAD);
            else if (rcd_rem_q != '0)
                rcd_rem_q <= rcd_rem_q - 1'b1;
            if (pre_go)
                rp_rem_q <= CW'(RP_LOAD);
            else if (rp_rem_q != '0)
                rp_rem_q <= rp_rem_q - 1'b1;
        end
    end
`else
    assign timing_viol = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_CLOSED;
            row_q      <= '0;
            row_open_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (cmd_bad || (cmd_act && state_q == ST_OPEN) ||
                ((cmd_rd || cmd_wr) && state_q == ST_CLOSED) || timing_viol)
                err_q <= 1'b1;
            case (state_q)
                ST_CLOSED: if (cmd_act) begin
                    row_q      <= A[ROW_BITS-1:0];
                    state_q    <= ST_OPEN;
                    row_open_q <= 1'b1;
                end
                ST_OPEN: if (cmd_pre) begin
                    state_q    <= ST_CLOSED;
                    row_open_q <= 1'b0;
                end
                default: state_q <= ST_CLOSED;
            endcase
        end
    end

    // One RAM per byte lane; the read register holds its word until the next READ.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_q;
            always_ff @(posedge ACLK) begin
                if (wr_go && !ARESET && !WEn[gi])
                    lane_mem[mem_addr] <= D[8*gi +: 8];
                if (ARESET)
                    lane_rd_q <= '0;
                else if (rd_go)
                    lane_rd_q <= lane_mem[mem_addr];
            end
            assign mem_rd_word[8*gi +: 8] = lane_rd_q;
        end
    endgenerate

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_v_q <= '0;
        end else begin
            rd_v_q[0] <= rd_go;
            for (int k = 1; k < CL; k++)
                rd_v_q[k] <= rd_v_q[k-1];
        end
    end

    // Data stages advance only with a valid token, so Q holds between bursts.
    generate
        if (CL == 1) begin : g_q_direct
            assign Q = mem_rd_word;
        end else begin : g_q_pipe
            logic [31:0] pipe_d_q [CL-1];
            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    for (int j = 0; j < CL - 1; j++)
                        pipe_d_q[j] <= '0;
                end else begin
                    if (rd_v_q[0])
                        pipe_d_q[0] <= mem_rd_word;
                    for (int j = 1; j < CL - 1; j++)
                        if (rd_v_q[j])
                            pipe_d_q[j] <= pipe_d_q[j-1];
                end
            end
            assign Q = pipe_d_q[CL-2];
        end
    endgenerate

    assign VALID    = rd_v_q[CL-1];
    assign ROW_OPEN = row_open_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_dram_cmd_model.sv
// Randomised + directed bench for dram_cmd_model against an edge-distance/queue model.
// Honours `DRAM_TIMING_CHECK_EN so the same bench fits both builds.
module tb_dram_cmd_model;
    localparam int CL    = 5;
    localparam int T_RCD = 5;
    localparam int T_RP  = 5;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        CSn = 1'b1, RASn = 1'b1, CASn = 1'b1;
    logic [3:0]  WEn = 4'hF;
    logic [10:0] A = '0;
    logic [31:0] D = '0;
    logic [31:0] Q;
    logic        VALID, ROW_OPEN, ERR;

    dram_cmd_model #(.ROW_BITS(11), .COL_BITS(10), .CL(CL), .T_RCD(T_RCD), .T_RP(T_RP)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .CSn(CSn), .RASn(RASn), .CASn(CASn),
        .WEn(WEn), .A(A), .D(D), .Q(Q), .VALID(VALID), .ROW_OPEN(ROW_OPEN), .ERR(ERR)
    );

    initial forever #5 ACLK = ~ACLK;

    // Reference model state
    typedef struct { int due; logic [31:0] d; logic [3:0] k; } rd_t;
    rd_t         pq[$];
    logic [31:0] m_mem   [int];
    logic [3:0]  m_known [int];
    int          edge_n = 0;
    int          last_act = -1000, last_pre = -1000;
    bit          m_open = 0, m_err = 0;
    logic [10:0] m_row = '0;
    bit          exp_valid = 0;
    logic [31:0] exp_q = '0;
    logic [3:0]  exp_k = 4'hF;
    bit          chk_en = 0;
    int          total = 0, bad = 0;

    task automatic check(string nm, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", nm, got, want, edge_n);
        end
    endtask

    function automatic logic [31:0] bmask(logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    // Applies the rules to whatever is on the pins at the edge just taken.
    task automatic model_edge();
        int addr;
        bit is_act, is_pre, is_rd, is_wr;
        edge_n++;
        exp_valid = 0;
        if (ARESET) begin
            m_open = 0; m_err = 0; pq.delete();
            exp_q = '0; exp_k = 4'hF;
            last_act = -1000; last_pre = -1000;
            return;
        end
        is_act = !CSn && !RASn && CASn && WEn == 4'hF;
        is_pre = !CSn && !RASn && CASn && WEn == 4'h0;
        is_rd  = !CSn && RASn && !CASn && WEn == 4'hF;
        is_wr  = !CSn && RASn && !CASn && WEn != 4'hF;
        if (!CSn && !RASn && WEn != 4'hF && WEn != 4'h0) begin
            m_err = 1;
        end else if (is_act) begin
            if (m_open) m_err = 1;
            else begin
`ifdef DRAM_TIMING_CHECK_EN
                if (edge_n - last_pre < T_RP) m_err = 1;
`endif
                m_open = 1; m_row = A; last_act = edge_n;
            end
        end else if (is_pre) begin
            if (m_open) begin m_open = 0; last_pre = edge_n; end
        end else if (is_rd || is_wr) begin
            if (!m_open) m_err = 1;
            else begin
`ifdef DRAM_TIMING_CHECK_EN
                if (edge_n - last_act < T_RCD) m_err = 1;
`endif
                addr = int'({m_row, A[9:0]});
                if (is_rd) begin
                    rd_t e;
                    e.due = edge_n + CL - 1;
                    e.d = m_mem.exists(addr) ? m_mem[addr] : '0;
                    e.k = m_known.exists(addr) ? m_known[addr] : 4'h0;
                    pq.push_back(e);
                end else begin
                    logic [31:0] w;
                    logic [3:0]  k;
                    w = m_mem.exists(addr) ? m_mem[addr] : '0;
                    k = m_known.exists(addr) ? m_known[addr] : 4'h0;
                    for (int b = 0; b < 4; b++)
                        if (!WEn[b]) begin w[8*b +: 8] = D[8*b +: 8]; k[b] = 1'b1; end
                    m_mem[addr] = w; m_known[addr] = k;
                end
            end
        end
        if (pq.size() > 0 && pq[0].due == edge_n) begin
            exp_valid = 1; exp_q = pq[0].d; exp_k = pq[0].k;
            void'(pq.pop_front());
        end
    endtask

    always @(negedge ACLK) begin
        if (chk_en) begin
            check("valid", 32'(VALID), 32'(exp_valid));
            check("row_open", 32'(ROW_OPEN), 32'(m_open));
            check("err", 32'(ERR), 32'(m_err));
            check("q", Q & bmask(exp_k), exp_q & bmask(exp_k));
            if (exp_valid) $display("read return edge=%0d q=%h", edge_n, Q);
        end
    end

    task automatic step(bit rst, bit csn, bit rasn, bit casn, logic [3:0] wen,
                        logic [10:0] a, logic [31:0] d);
        ARESET = rst; CSn = csn; RASn = rasn; CASn = casn; WEn = wen; A = a; D = d;
        @(posedge ACLK);
        model_edge();
        #1;
    endtask

    task automatic nop();                     step(0, 1, 1, 1, 4'hF, '0, '0);  endtask
    task automatic nops(int n);               for (int i = 0; i < n; i++) nop(); endtask
    task automatic rst();                     step(1, 1, 1, 1, 4'hF, '0, '0);  endtask
    task automatic act(logic [10:0] r);       step(0, 0, 0, 1, 4'hF, r, '0);   endtask
    task automatic pre();                     step(0, 0, 0, 1, 4'h0, '0, '0);  endtask
    task automatic rd(logic [10:0] c);        step(0, 0, 1, 0, 4'hF, c, '0);   endtask
    task automatic wr(logic [10:0] c, logic [3:0] wen, logic [31:0] d);
        step(0, 0, 1, 0, wen, c, d);
    endtask

    // Latency counted in cycles from the READ's cycle; -1 on timeout.
    task automatic wait_valid(output int lat, output logic [31:0] qv);
        lat = -1; qv = '0;
        for (int i = 1; i <= 20; i++) begin
            nop();
            if (VALID) begin lat = i + 1; qv = Q; break; end
        end
    endtask

    task automatic count_valid(int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin nop(); if (VALID) cnt++; end
    endtask

    int          lat, cnt;
    logic [31:0] qv;

    initial begin
        rst();
        chk_en = 1;
        check("reset_q", Q, 32'h0);
        check("reset_valid", 32'(VALID), 32'h0);
        check("reset_row_open", 32'(ROW_OPEN), 32'h0);
        check("reset_err", 32'(ERR), 32'h0);

        // Full write then read-back through a PRE/ACT cycle
        act(11'h005); nops(5);
        wr(11'h010, 4'h0, 32'hDEADBEEF);
        pre(); nops(5);
        act(11'h005); nops(5);
        rd(11'h010);
        wait_valid(lat, qv);
        check("t1_latency", 32'(lat), 32'd5);
        check("t1_q", qv, 32'hDEADBEEF);
        check("t1_err", 32'(ERR), 32'h0);

        // Partial write of the two low bytes
        wr(11'h010, 4'b1100, 32'h11223344);
        rd(11'h010);
        wait_valid(lat, qv);
        check("t2_q", qv, 32'hDEAD3344);

        // Back-to-back reads at the top of the column range
        wr(11'h3FE, 4'h0, 32'hA1B2C3D4);
        wr(11'h3FF, 4'h0, 32'h5566AA77);
        rd(11'h3FE); rd(11'h3FF);
        wait_valid(lat, qv);
        check("t3_first_q", qv, 32'hA1B2C3D4);
        nop();
        check("t3_second_valid", 32'(VALID), 32'h1);
        check("t3_second_q", Q, 32'h5566AA77);

        // Column command with no open row
        pre(); nops(5);
        rd(11'h010);
        count_valid(8, cnt);
        check("t4_closed_rd_err", 32'(ERR), 32'h1);
        check("t4_closed_rd_valid", 32'(cnt), 32'h0);

        // Second ACT on an open row keeps the original row
        rst();
        act(11'h007); nops(5);
        wr(11'h020, 4'h0, 32'hCAFE0007);
        act(11'h009);
        check("t4_dup_act_err", 32'(ERR), 32'h1);
        rd(11'h020);
        wait_valid(lat, qv);
        check("t4_row_kept_q", qv, 32'hCAFE0007);

        // READ three cycles after ACT
        rst();
        act(11'h001); nops(5);
        wr(11'h030, 4'h0, 32'h0BADF00D);
        pre(); nops(5);
        act(11'h001); nops(2);
        rd(11'h030);
`ifdef DRAM_TIMING_CHECK_EN
        check("t5_trcd_err", 32'(ERR), 32'h1);
`else
        check("t5_trcd_err", 32'(ERR), 32'h0);
`endif
        wait_valid(lat, qv);
        check("t5_latency", 32'(lat), 32'd5);
        check("t5_q", qv, 32'h0BADF00D);

        // Reset two cycles after a READ drops it; memory survives
        rst();
        act(11'h002); nops(5);
        wr(11'h040, 4'h0, 32'h600DD00D);
        rd(11'h040); nop();
        rst();
        count_valid(8, cnt);
        check("t6_dropped_valid", 32'(cnt), 32'h0);
        check("t6_row_open", 32'(ROW_OPEN), 32'h0);
        check("t6_q", Q, 32'h0);
        act(11'h002); nops(5);
        rd(11'h040);
        wait_valid(lat, qv);
        check("t6_retained_q", qv, 32'h600DD00D);

        // Random traffic over a small address window
        rst();
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [10:0] row, col;
            r   = $urandom_range(0, 99);
            row = 11'($urandom_range(0, 3));
            col = 11'($urandom_range(0, 7)) | (11'($urandom_range(0, 1)) << 10);
            if (r < 1)       rst();
            else if (r < 4)  step(0, 1, 1'($urandom), 1'($urandom), 4'($urandom), col, $urandom);
            else if (r < 6)  step(0, 0, 0, 1'($urandom), 4'($urandom_range(1, 14)), col, $urandom);
            else if (r < 14) act(row);
            else if (r < 21) pre();
            else if (r < 50) rd(col);
            else if (r < 78) wr(col, 4'($urandom_range(0, 14)), $urandom);
            else             nop();
        end
        nops(CL + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram_cmd_model.md
Name: dram_cmd_model

Overview:
- Cycle-accurate behavioural model of the off-chip DRAM device.
- Sits directly downstream of the DRAM AXI wrapper and consumes its command pins (CSn/RASn/CASn/WEn/A/D).
- Returns read data on Q with a one-cycle VALID strobe after a fixed CAS latency.
- Tracks the open-row state, enforces command timing, and flags protocol violations for the verification bench.

Parameters:
- ROW_BITS, 11, row address width taken from A[ROW_BITS-1:0] on ACT.
- COL_BITS, 10, column address width taken from A[COL_BITS-1:0] on READ/WRITE.
- CL, 5, CAS latency in cycles, legal range 1..7.
- T_RCD, 5, minimum cycles from ACT to READ/WRITE.
- T_RP, 5, minimum cycles from PRE to the next ACT.

Ports:
- ACLK  input  1  clock; all logic on the rising edge.
- ARESET  input  1  synchronous, active-high reset.
- CSn  input  1  chip select, active low.
- RASn  input  1  row strobe, active low.
- CASn  input  1  column strobe, active low.
- WEn  input  4  per-byte write enable, active low.
- A  input  11  row or column address.
- D  input  32  write data.
- Q  output  32  read data.
- VALID  output  1  Q valid strobe.
- ROW_OPEN  output  1  high while a row is active.
- ERR  output  1  sticky protocol-violation flag.

Behaviour:
- Clock and reset: one clock, ACLK. ARESET is synchronous and active-high.
- Reset values: Q=0, VALID=0, ROW_OPEN=0, ERR=0. Reset also flushes the read pipeline and zeroes the timing counters. Memory array contents are retained; reset mid-burst drops all in-flight reads.
- Command decode (sampled at a rising edge when CSn=0):
  - ACT: RASn=0, CASn=1, WEn=1111.
  - READ: RASn=1, CASn=0, WEn=1111.
  - WRITE: RASn=1, CASn=0, WEn!=1111.
  - PRE: RASn=0, CASn=1, WEn=0000.
  - Anything else, or CSn=1, is a NOP. RASn=0 with WEn neither 1111 nor 0000 is an illegal command: sets ERR and is otherwise ignored.
- Bank FSM:
  - CLOSED: ACT latches row=A[ROW_BITS-1:0] and moves to OPEN. ROW_OPEN=1 from the next cycle.
  - OPEN: PRE moves to CLOSED. A second ACT sets ERR and is ignored.
  - PRE while CLOSED is a legal NOP.
  - READ or WRITE while CLOSED sets ERR and is ignored.
- Array: 2^(ROW_BITS+COL_BITS) words of 32 bits, indexed by {row, A[COL_BITS-1:0]}. A[10] is ignored on column commands.
- WRITE: byte i = D[8i+7:8i] is written where WEn[i]=0. The write takes effect at the sampling edge; no write latency.
- READ pipeline:
  - Array word is captured at the command edge.
  - For a READ sampled at edge n, VALID=1 and Q=word during the cycle after edge n+CL-1. With CL=5 and the READ in cycle c, VALID is high in cycle c+5.
  - The pipeline is CL deep and accepts a READ every cycle.
  - Q holds its last value while VALID=0.
  - WRITE and READ to the same address on the same edge: the read returns old data. A WRITE after a READ never alters that READ's data.
- Timing counters:
  - The ACT→column counter starts at ACT. A READ/WRITE fewer than T_RCD cycles after ACT (edge distance < T_RCD) is a violation.
  - The PRE→ACT counter starts at PRE. An ACT fewer than T_RP cycles after PRE is a violation.
  - Counters saturate; they do not wrap.
- ERR: set on any violation, cleared only by ARESET.

Optional Feature:
- Macro: DRAM_TIMING_CHECK_EN.
- Defined: T_RCD and T_RP violations set ERR, and the offending command is still executed.
- Undefined: the timing counters are not built and only FSM-state violations and illegal commands set ERR.

Test Plan:
- ACT row 0x005, 5 NOPs, WRITE col 0x010 D=0xDEADBEEF WEn=0000, PRE, 5 NOPs, ACT 0x005, READ 0x010 -> VALID exactly 5 cycles after READ, Q=0xDEADBEEF, ERR=0.
- Partial write WEn=1100 D=0x11223344 over 0xDEADBEEF, then read -> Q=0xDEAD3344.
- Back-to-back READs of cols 0x3FE, 0x3FF on consecutive cycles -> VALID high for two consecutive cycles with data in order.
- READ with no open row -> ERR=1, no VALID. ACT while a row is open -> ERR=1, row unchanged.
- With DRAM_TIMING_CHECK_EN: READ 3 cycles after ACT -> ERR=1 and data still returned after CL. Without the macro, the same stimulus -> ERR=0.
- ARESET asserted 2 cycles after a READ -> VALID never asserts, ROW_OPEN=0, Q=0. A later read after re-ACT returns pre-reset memory contents.
